// File: rtl/k6502_seq_pkg.sv
// Shared definitions for the k6502 sequencer: control-word layout, field values,
// one-hot cycle encoding and the decoded control struct.
package k6502_seq_pkg;

    localparam int X_BITS = 8;

    // Bit positions of the fields inside the decoder control word x.
    localparam int X_ADDR_MODE  = 0;
    localparam int X_DL_LATCH_L = 1;
    localparam int X_DL_LATCH_H = 2;
    localparam int X_INC_DL     = 3;
    localparam int X_PC_LATCH_L = 4;
    localparam int X_PC_LATCH_H = 5;
    localparam int X_INC_PC     = 6;
    localparam int X_SYNC_NEXT  = 7;

    localparam logic ADDR_MODE_PC = 1'b0;
    localparam logic ADDR_MODE_DL = 1'b1;

    typedef enum logic [5:0] {
        CYC_SYNC = 6'b000000,
        CYC_1    = 6'b000001,
        CYC_2    = 6'b000010,
        CYC_3    = 6'b000100,
        CYC_4    = 6'b001000,
        CYC_5    = 6'b010000,
        CYC_6    = 6'b100000
    } cycle_e;

    typedef struct packed {
        logic sync_next;
        logic inc_pc;
        logic pc_latch_h;
        logic pc_latch_l;
        logic inc_dl;
        logic dl_latch_h;
        logic dl_latch_l;
        logic addr_mode;
    } ctrl_t;

    function automatic ctrl_t decode_x(input logic [X_BITS-1:0] x);
        ctrl_t c;
        c.addr_mode  = x[X_ADDR_MODE];
        c.dl_latch_l = x[X_DL_LATCH_L];
        c.dl_latch_h = x[X_DL_LATCH_H];
        c.inc_dl     = x[X_INC_DL];
        c.pc_latch_l = x[X_PC_LATCH_L];
        c.pc_latch_h = x[X_PC_LATCH_H];
        c.inc_pc     = x[X_INC_PC];
        c.sync_next  = x[X_SYNC_NEXT];
        return c;
    endfunction

endpackage

// File: rtl/k6502_addr_regs.sv
// Address datapath: PC, DL pointer latch, PC-low staging byte and the
// combinational address mux feeding the memory bus.
module k6502_addr_regs
    import k6502_seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [7:0]  data_in,
    input  ctrl_t       ctrl,
    output logic [15:0] addr
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] dl_q, dl_d;
    logic [7:0]  pcl_hold_q, pcl_hold_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pc_d       = pc_q;
        dl_d       = dl_q;
        pcl_hold_d = pcl_hold_q;

        if (ctrl.pc_latch_h) begin
            pc_d = {data_in, pcl_hold_q};
        end else if (ctrl.inc_pc) begin
            pc_d = pc_q + 16'd1;
        end

        if (ctrl.pc_latch_l) begin
            pcl_hold_d = data_in;
        end

        // Low-byte increment stays inside the page, as JMP ($xxFF) requires.
        if (ctrl.dl_latch_l) begin
            dl_d[7:0] = data_in;
        end else if (ctrl.inc_dl) begin
            dl_d[7:0] = dl_q[7:0] + 8'd1;
        end

        if (ctrl.dl_latch_h) begin
            dl_d[15:8] = data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            pc_q       <= RESET_PC;
            dl_q       <= 16'h0000;
            pcl_hold_q <= 8'h00;
        end else if (rdy) begin
            pc_q       <= pc_d;
            dl_q       <= dl_d;
            pcl_hold_q <= pcl_hold_d;
        end
    end

    assign addr = (ctrl.addr_mode == ADDR_MODE_DL) ? dl_q : pc_q;

endmodule

// File: rtl/k6502_seq.sv
// k6502 cycle sequencer: instruction register, one-hot step counter and the
// microcode overflow flag, wrapped around the address datapath.
module k6502_seq
    import k6502_seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    input  logic [7:0]        data_in,
    input  logic [X_BITS-1:0] x,
    output logic [15:0]       addr,
    output logic [7:0]        ir,
    output logic [5:0]        cycle,
    output logic              sync,
    output logic              ucode_err
);

    ctrl_t  ctrl;
    cycle_e cycle_q, cycle_d;
    logic [7:0] ir_q, ir_d;
    logic   err_q, err_d;

    assign ctrl = decode_x(x);

    k6502_addr_regs #(
        .RESET_PC(RESET_PC)
    ) u_addr_regs (
        .clk    (clk),
        .reset  (reset),
        .rdy    (rdy),
        .data_in(data_in),
        .ctrl   (ctrl),
        .addr   (addr)
    );

    always_comb begin
        cycle_d = cycle_q;
        ir_d    = ir_q;
        err_d   = err_q;

        case (cycle_q)
            CYC_SYNC: begin
                // The opcode fetch always advances; SYNC_NEXT is meaningless here.
                ir_d    = data_in;
                cycle_d = CYC_1;
            end
            CYC_1, CYC_2, CYC_3, CYC_4, CYC_5: begin
                cycle_d = ctrl.sync_next ? CYC_SYNC : cycle_e'({cycle_q[4:0], 1'b0});
            end
            CYC_6: begin
                cycle_d = CYC_SYNC;
                if (!ctrl.sync_next) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                cycle_d = CYC_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= CYC_SYNC;
            ir_q    <= 8'h00;
            err_q   <= 1'b0;
        end else if (rdy) begin
            cycle_q <= cycle_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    assign ir        = ir_q;
    assign cycle     = cycle_q;
    assign sync      = (cycle_q == CYC_SYNC);
    assign ucode_err = err_q;

endmodule
